df_mid_tdatq_deq13: RTL and testbench
=====================================

DF_MID_TDATQ_DEQ13 -- requirements
Module: df_mid_tdatq_deq13

Interface
REQ-001 Parameter WIDTH, default 4, packet width per queue entry.
REQ-002 Parameter DEPTH, default 4, number of queue entries.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 QVect  input  DEPTH*WIDTH  queue contents; entry i is bits [i*WIDTH +: WIDTH].
REQ-006 Valid  input  DEPTH  queue entry valid bits.
REQ-007 Oldest  input  DEPTH  queue one-hot oldest entry among Pickable; zero when none.
REQ-008 Pickable  output  DEPTH  pick mask driven back to the queue.
REQ-009 DelValid  output  DEPTH  one-cycle delete pulse to the queue.
REQ-010 DeqVld  output  1  dequeued packet valid.
REQ-011 DeqRdy  input  1  consumer ready.
REQ-012 DeqPkt  output  WIDTH  dequeued packet.
REQ-013 DeqIx  output  DEPTH  one-hot source index of DeqPkt.
REQ-014 Flush  input  1  abandon in-flight dequeue.
REQ-015 DeqCnt  output  8  completed-handshake counter.
REQ-016 OneHotErr  output  1  sticky flag, Oldest had more than one bit set.

Function
REQ-017 Pickable SHALL be combinational: Valid & ~InFlight, forced to zero while Flush=1 or state=FLUSH.
REQ-018 InFlight SHALL be a DEPTH-bit register marking entries already picked and not yet deleted.
REQ-019 Pick qualifier: Pick = Oldest & Pickable, non-zero and one-hot; if Oldest is non-zero but Pick is zero, no pick occurs.
REQ-020 FSM states SHALL be IDLE, LOADED and FLUSH.
REQ-021 IDLE: on a valid Pick, capture the QVect slice selected by Pick into DeqPkt, set DeqIx=Pick and InFlight|=Pick, and go to LOADED; otherwise stay in IDLE.
REQ-022 Latency: Pick valid in cycle N gives DeqVld=1 in cycle N+1.
REQ-023 LOADED: DeqVld=1; DeqPkt and DeqIx SHALL hold stable while DeqRdy=0.
REQ-024 Handshake in cycle N (DeqVld&DeqRdy):
- DelValid=DeqIx in cycle N+1 only.
- DeqCnt increments by 1, wrapping 255->0.
- The matching InFlight bit clears at the end of cycle N+1.
REQ-025 Handshake plus a valid Pick in the same cycle: reload DeqPkt/DeqIx and stay in LOADED, giving one packet per cycle.
REQ-026 Handshake with no valid Pick: go to IDLE, DeqVld=0 next cycle.
REQ-027 A multi-hot Oldest SHALL set OneHotErr (held until Reset), and no pick occurs that cycle.
REQ-028 Flush=1 in any state: next cycle enters FLUSH.
- DeqVld=0; InFlight cleared; no DelValid for the dropped packet.
- A handshake coincident with Flush is ignored: no DelValid, no DeqCnt change.
REQ-029 FLUSH SHALL last exactly one cycle with no pick, then go to IDLE (or stay in FLUSH if Flush is still 1).
REQ-030 A pending DelValid pulse from a handshake in the cycle before Flush SHALL still be issued.
REQ-031 Only one DeqIx bit is outstanding in the output stage; DelValid is at most one-hot.

Reset
REQ-032 While Reset=1, the following SHALL be zero on the next edge: state=IDLE, InFlight, DeqVld, DeqPkt, DeqIx, DelValid, DeqCnt, OneHotErr.
REQ-033 Reset SHALL override Flush, handshake and pick in the same cycle.
REQ-034 Reset asserted mid-transfer SHALL drop the packet with no DelValid issued.

Verification
REQ-035 Single pick: Valid=0001, Oldest=0001, QVect entry0=A, DeqRdy=1 -> cycle+1 DeqVld=1, DeqPkt=A, DeqIx=0001; cycle+2 DelValid=0001, DeqCnt=1.
REQ-036 Backpressure: DeqRdy=0 for 3 cycles with entry2=5 loaded -> DeqPkt=5 and DeqIx=0100 stable, Pickable[2]=0, no DelValid; DeqRdy=1 -> DelValid=0100 next cycle.
REQ-037 Streaming: Valid=1111, Oldest walks 0010,1000,0001,0100, DeqRdy=1 -> four consecutive DeqVld cycles in that order; DelValid follows one cycle later each; DeqCnt=4.
REQ-038 Flush: entry1 loaded, DeqRdy=0, Flush=1 -> next cycle DeqVld=0, InFlight=0, no DelValid, DeqCnt unchanged; Pickable=Valid after the FLUSH cycle.
REQ-039 Errors and wrap:
- Oldest=0011 -> OneHotErr=1, no pick; it stays 1 until Reset.
- 256 handshakes -> DeqCnt wraps to 0.
REQ-040 Reset mid-transfer: Reset=1 while LOADED with DeqRdy=1 -> all outputs 0 next cycle, no DelValid.

Source files
------------

// File: rtl/df_mid_tdatq_deq13_if.sv
// Queue-to-dequeue-stage bundle: queue contents, pick mask, delete pulse and the
// downstream valid/ready packet port.
interface df_mid_tdatq_deq13_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic [DEPTH*WIDTH-1:0] QVect;
  logic [DEPTH-1:0]       Valid;
  logic [DEPTH-1:0]       Oldest;
  logic [DEPTH-1:0]       Pickable;
  logic [DEPTH-1:0]       DelValid;
  logic                   DeqVld;
  logic                   DeqRdy;
  logic [WIDTH-1:0]       DeqPkt;
  logic [DEPTH-1:0]       DeqIx;
  logic                   Flush;
  logic [7:0]             DeqCnt;
  logic                   OneHotErr;

  // Queue/consumer side
  modport master (
    output QVect, Valid, Oldest, DeqRdy, Flush,
    input  Pickable, DelValid, DeqVld, DeqPkt, DeqIx, DeqCnt, OneHotErr
  );

  // Dequeue stage side
  modport slave (
    input  QVect, Valid, Oldest, DeqRdy, Flush,
    output Pickable, DelValid, DeqVld, DeqPkt, DeqIx, DeqCnt, OneHotErr
  );
endinterface

// File: rtl/df_mid_tdatq_deq13.sv
// Single-entry dequeue stage: picks the oldest pickable queue entry, holds it
// under backpressure, and pulses a delete back to the queue after the handshake.
module df_mid_tdatq_deq13 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset,
  df_mid_tdatq_deq13_if.slave q
);

  typedef enum logic [1:0] {IDLE, LOADED, FLUSH} state_t;

  localparam logic [DEPTH-1:0] ONE_D = DEPTH'(1);

  state_t           state_q, state_d;
  logic [DEPTH-1:0] inflight_q, inflight_d;
  logic [DEPTH-1:0] ix_q, ix_d;
  logic [DEPTH-1:0] del_q, del_d;
  logic [WIDTH-1:0] pkt_q, pkt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] pickable;
  logic [DEPTH-1:0] pick;
  logic [WIDTH-1:0] pick_pkt;
  logic             multi_hot;
  logic             pick_ok;
  logic             hs;

  function automatic logic is_multi_hot(input logic [DEPTH-1:0] v);
    return (v & (v - ONE_D)) != '0;
  endfunction

  function automatic logic is_one_hot(input logic [DEPTH-1:0] v);
    return (v != '0) && !is_multi_hot(v);
  endfunction

  always_comb begin
    pickable = '0;
    if (!q.Flush && state_q != FLUSH) pickable = q.Valid & ~inflight_q;
  end

  // A multi-hot Oldest vetoes the pick even if only one of its bits is pickable
  assign pick      = q.Oldest & pickable;
  assign multi_hot = is_multi_hot(q.Oldest);
  assign pick_ok   = is_one_hot(pick) && !multi_hot;
  assign hs        = (state_q == LOADED) && q.DeqRdy;

  always_comb begin
    pick_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) pick_pkt = pick_pkt | q.QVect[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    ix_d       = ix_q;
    cnt_d      = cnt_q;
    del_d      = '0;
    err_d      = err_q | multi_hot;
    // The entry deleted this cycle leaves the in-flight set at this edge
    inflight_d = inflight_q & ~del_q;

    if (q.Flush) begin
      state_d    = FLUSH;
      inflight_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_ok) begin
            pkt_d      = pick_pkt;
            ix_d       = pick;
            inflight_d = inflight_d | pick;
            state_d    = LOADED;
          end
        end
        LOADED: begin
          if (hs) begin
            del_d = ix_q;
            cnt_d = cnt_q + 8'd1;
            if (pick_ok) begin
              pkt_d      = pick_pkt;
              ix_d       = pick;
              inflight_d = inflight_d | pick;
            end else begin
              state_d = IDLE;
            end
          end
        end
        FLUSH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      pkt_q      <= '0;
      ix_q       <= '0;
      del_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      pkt_q      <= pkt_d;
      ix_q       <= ix_d;
      del_q      <= del_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign q.Pickable  = pickable;
  assign q.DelValid  = del_q;
  assign q.DeqVld    = (state_q == LOADED);
  assign q.DeqPkt    = pkt_q;
  assign q.DeqIx     = ix_q;
  assign q.DeqCnt    = cnt_q;
  assign q.OneHotErr = err_q;

endmodule

// File: tb/tb_df_mid_tdatq_deq13.sv
// Directed bench for df_mid_tdatq_deq13: pick, backpressure, streaming, flush,
// error flag, counter wrap and reset mid-transfer.
module tb_df_mid_tdatq_deq13;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic Clk = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_err = 0;

  df_mid_tdatq_deq13_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  df_mid_tdatq_deq13 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    bus.QVect  = '0;
    bus.Valid  = '0;
    bus.Oldest = '0;
    bus.DeqRdy = 1'b0;
    bus.Flush  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    chk("rst_vld", 32'(bus.DeqVld), 0);
    chk("rst_pkt", 32'(bus.DeqPkt), 0);
    chk("rst_ix",  32'(bus.DeqIx), 0);
    chk("rst_del", 32'(bus.DelValid), 0);
    chk("rst_cnt", 32'(bus.DeqCnt), 0);
    chk("rst_err", 32'(bus.OneHotErr), 0);
    Reset = 1'b0;

    // Single pick of entry0 = A
    bus.QVect = 16'h000A; bus.Valid = 4'b0001; bus.Oldest = 4'b0001; bus.DeqRdy = 1'b1;
    #1;
    chk("single_pickable", 32'(bus.Pickable), 4'b0001);
    cyc();
    chk("single_vld", 32'(bus.DeqVld), 1);
    chk("single_pkt", 32'(bus.DeqPkt), 4'hA);
    chk("single_ix",  32'(bus.DeqIx), 4'b0001);
    chk("single_pickable_inflight", 32'(bus.Pickable), 4'b0000);
    bus.Valid = '0; bus.Oldest = '0;
    cyc();
    chk("single_del", 32'(bus.DelValid), 4'b0001);
    chk("single_cnt", 32'(bus.DeqCnt), 1);
    chk("single_vld_off", 32'(bus.DeqVld), 0);
    cyc();
    chk("single_del_off", 32'(bus.DelValid), 0);

    // Backpressure with entry2 = 5
    bus.QVect = 16'h0500; bus.Valid = 4'b0100; bus.Oldest = 4'b0100; bus.DeqRdy = 1'b0;
    cyc();
    chk("bp_load_vld", 32'(bus.DeqVld), 1);
    bus.Oldest = '0; bus.QVect = 16'h0900;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_pkt", 32'(bus.DeqPkt), 4'h5);
      chk("bp_ix",  32'(bus.DeqIx), 4'b0100);
      chk("bp_del", 32'(bus.DelValid), 0);
      chk("bp_pickable", 32'(bus.Pickable), 4'b0000);
    end
    bus.DeqRdy = 1'b1;
    cyc();
    chk("bp_del", 32'(bus.DelValid), 4'b0100);
    chk("bp_cnt", 32'(bus.DeqCnt), 2);
    chk("bp_vld_off", 32'(bus.DeqVld), 0);
    cyc();
    chk("bp_del_off", 32'(bus.DelValid), 0);
    chk("bp_pickable_free", 32'(bus.Pickable), 4'b0100);
    bus.Valid = '0;

    // Streaming: e0=1 e1=2 e2=3 e3=4, Oldest walks 0010,1000,0001,0100
    do_reset();
    bus.QVect = 16'h4321; bus.Valid = 4'b1111; bus.DeqRdy = 1'b1; bus.Oldest = 4'b0010;
    cyc();
    chk("st0_ix",  32'(bus.DeqIx), 4'b0010);
    chk("st0_pkt", 32'(bus.DeqPkt), 4'h2);
    bus.Oldest = 4'b1000;
    cyc();
    chk("st1_ix",  32'(bus.DeqIx), 4'b1000);
    chk("st1_pkt", 32'(bus.DeqPkt), 4'h4);
    chk("st1_del", 32'(bus.DelValid), 4'b0010);
    bus.Oldest = 4'b0001;
    cyc();
    chk("st2_ix",  32'(bus.DeqIx), 4'b0001);
    chk("st2_pkt", 32'(bus.DeqPkt), 4'h1);
    chk("st2_del", 32'(bus.DelValid), 4'b1000);
    bus.Oldest = 4'b0100;
    cyc();
    chk("st3_ix",  32'(bus.DeqIx), 4'b0100);
    chk("st3_pkt", 32'(bus.DeqPkt), 4'h3);
    chk("st3_del", 32'(bus.DelValid), 4'b0001);
    chk("st3_vld", 32'(bus.DeqVld), 1);
    bus.Oldest = '0; bus.Valid = '0;
    cyc();
    chk("st_end_vld", 32'(bus.DeqVld), 0);
    chk("st_end_del", 32'(bus.DelValid), 4'b0100);
    chk("st_cnt", 32'(bus.DeqCnt), 4);

    // Flush with entry1 = B loaded; coincident handshake ignored
    bus.QVect = 16'h00B0; bus.Valid = 4'b0010; bus.Oldest = 4'b0010; bus.DeqRdy = 1'b0;
    cyc();
    chk("fl_load_ix", 32'(bus.DeqIx), 4'b0010);
    bus.Oldest = '0; bus.Flush = 1'b1; bus.DeqRdy = 1'b1;
    #1;
    chk("fl_pickable_flush", 32'(bus.Pickable), 0);
    cyc();
    chk("fl_vld", 32'(bus.DeqVld), 0);
    chk("fl_del", 32'(bus.DelValid), 0);
    chk("fl_cnt", 32'(bus.DeqCnt), 4);
    bus.Flush = 1'b0; bus.DeqRdy = 1'b0;
    #1;
    chk("fl_pickable_state", 32'(bus.Pickable), 0);
    cyc();
    chk("fl_pickable_after", 32'(bus.Pickable), 4'b0010);
    chk("fl_del_after", 32'(bus.DelValid), 0);

    // Handshake in the cycle before Flush still issues its DelValid
    bus.QVect = 16'h0007; bus.Valid = 4'b0001; bus.Oldest = 4'b0001;
    cyc();
    bus.Oldest = '0; bus.DeqRdy = 1'b1;
    cyc();
    bus.Flush = 1'b1;
    #1;
    chk("pre_fl_del", 32'(bus.DelValid), 4'b0001);
    chk("pre_fl_cnt", 32'(bus.DeqCnt), 5);
    cyc();
    bus.Flush = 1'b0; bus.DeqRdy = 1'b0; bus.Valid = '0;
    cyc();

    // Multi-hot Oldest and unpickable Oldest
    bus.QVect = 16'h00CD; bus.Valid = 4'b0011; bus.Oldest = 4'b0011;
    cyc();
    chk("err_set", 32'(bus.OneHotErr), 1);
    chk("err_nopick", 32'(bus.DeqVld), 0);
    bus.Valid = 4'b0001;
    cyc();
    chk("err_partial_nopick", 32'(bus.DeqVld), 0);
    bus.Valid = '0; bus.Oldest = 4'b0001;
    cyc();
    chk("unpickable_nopick", 32'(bus.DeqVld), 0);
    chk("err_sticky", 32'(bus.OneHotErr), 1);
    do_reset();
    chk("err_cleared", 32'(bus.OneHotErr), 0);

    // 256 handshakes rotating over three entries
    bus.QVect = 16'h0321; bus.Valid = 4'b0111; bus.DeqRdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.Oldest = 4'(1 << (i % 3));
      cyc();
    end
    chk("wrap_255", 32'(bus.DeqCnt), 255);
    bus.Oldest = '0; bus.Valid = '0;
    cyc();
    chk("wrap_0", 32'(bus.DeqCnt), 0);
    chk("wrap_vld", 32'(bus.DeqVld), 0);
    cyc();

    // Reset mid-transfer
    bus.QVect = 16'h000E; bus.Valid = 4'b0001; bus.Oldest = 4'b0001; bus.DeqRdy = 1'b0;
    cyc();
    chk("mr_load_pkt", 32'(bus.DeqPkt), 4'hE);
    bus.Oldest = '0; bus.DeqRdy = 1'b1; Reset = 1'b1;
    cyc();
    chk("mr_vld", 32'(bus.DeqVld), 0);
    chk("mr_pkt", 32'(bus.DeqPkt), 0);
    chk("mr_ix",  32'(bus.DeqIx), 0);
    chk("mr_del", 32'(bus.DelValid), 0);
    Reset = 1'b0;
    cyc();
    chk("mr_del_after", 32'(bus.DelValid), 0);
    chk("mr_cnt", 32'(bus.DeqCnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
